pipelined_adder_tree: RTL and testbench

- Parametrised, registered successor to the fixed 4-input, 8-bit combinational adder tree.
- Sums numberOfInputs unsigned operands of numberOfBits each through a balanced binary tree, with one register stage per tree level.
- Carries full-precision results with a valid/ready handshake on both sides.
- Sits between operand producers and downstream arithmetic consumers that can apply backpressure.

---
 rtl/adder_tree_pkg.sv | 38 +++
 rtl/pipelined_add_stage.sv | 66 ++++++
 rtl/pipelined_adder_tree.sv | 72 +++++++
 tb/tb_pipelined_adder_tree.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the pipelined adder tree: tree depth, output
// width and per-level sum width, all derived from operand width and count.
package adder_tree_pkg;

  // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Number of tree levels, which is also the number of pipeline stages.
  function automatic int tree_depth(input int number_of_inputs);
    return clog2(number_of_inputs);
  endfunction

  // Full-precision width of the final sum.
  function automatic int result_bits(input int number_of_bits, input int number_of_inputs);
    return number_of_bits + tree_depth(number_of_inputs);
  endfunction

  // Width of each sum held at tree level k (level 0 = raw operands).
  function automatic int stage_bits(input int number_of_bits, input int level);
    return number_of_bits + level;
  endfunction

  // Number of sums held at tree level k.
  function automatic int stage_lanes(input int number_of_inputs, input int level);
    return number_of_inputs >> level;
  endfunction

endpackage

// File: rtl/pipelined_add_stage.sv
// One level of the adder tree: pairwise zero-extended adds of adjacent lanes,
// registered together with the level's valid bit. A nonzero clampBits makes
// this level saturate each sum to 2^clampBits - 1 before the register.
module pipelined_add_stage
  import adder_tree_pkg::*;
#(
  parameter int laneCount = 4,
  parameter int laneBits  = 8,
  parameter int clampBits = 0,
  localparam int outLanes = laneCount / 2,
  localparam int outBits  = stage_bits(laneBits, 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        advance_i,
  input  logic                        valid_i,
  input  logic [laneCount*laneBits-1:0] data_i,
  output logic                        valid_o,
  output logic [outLanes*outBits-1:0] data_o
);

  logic [outLanes*outBits-1:0] sum_c;
  logic [outLanes*outBits-1:0] data_d;
  logic [outLanes*outBits-1:0] data_q;
  logic                        valid_q;

  // Pairwise adds; one extra bit per level keeps every carry.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < outLanes; i++) begin
      sum_c[i*outBits +: outBits] = {1'b0, data_i[(2*i)*laneBits +: laneBits]}
                                  + {1'b0, data_i[(2*i+1)*laneBits +: laneBits]};
    end
  end

  if (clampBits > 0) begin : g_clamp
    localparam logic [outBits-1:0] SatMax = {{(outBits-clampBits){1'b0}}, {clampBits{1'b1}}};

    // Saturate each sum in front of the register so latency is unchanged.
    always_comb begin
      data_d = sum_c;
      for (int i = 0; i < outLanes; i++) begin
        if (sum_c[i*outBits +: outBits] > SatMax) begin
          data_d[i*outBits +: outBits] = SatMax;
        end
      end
    end
  end else begin : g_pass
    assign data_d = sum_c;
  end

  // Level register: loads only when the whole pipe advances; bubbles move too.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (advance_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Registered, parametrised adder tree with valid/ready on both sides.
// One register stage per tree level; result comes straight from the last
// stage's registers. Defining ADDER_TREE_SATURATE_EN clamps the final sum to
// 2^numberOfBits - 1 (upper result bits then always 0).
module pipelined_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int numberOfBits   = 8,
  parameter int numberOfInputs = 4,
  localparam int treeDepth     = tree_depth(numberOfInputs),
  localparam int resultBits    = result_bits(numberOfBits, numberOfInputs)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [numberOfInputs*numberOfBits-1:0] operands,
  input  logic                                 inValid,
  output logic                                 inReady,
  output logic [resultBits-1:0]                result,
  output logic                                 outValid,
  input  logic                                 outReady
);

`ifdef ADDER_TREE_SATURATE_EN
  localparam int clampBits = numberOfBits;
`else
  localparam int clampBits = 0;
`endif

  logic advance;

  // Whole pipe moves as one unit; never depends on inValid.
  assign advance = !outValid || outReady;
  assign inReady = advance;

  for (genvar k = 1; k <= treeDepth; k++) begin : g_stage
    localparam int inLanes    = stage_lanes(numberOfInputs, k - 1);
    localparam int inBits     = stage_bits(numberOfBits, k - 1);
    localparam int outWidth   = stage_lanes(numberOfInputs, k) * stage_bits(numberOfBits, k);
    localparam int stageClamp = (k == treeDepth) ? clampBits : 0;

    logic [inLanes*inBits-1:0] data_in;
    logic                      valid_in;
    logic [outWidth-1:0]       data_out;
    logic                      valid_out;

    if (k == 1) begin : g_first
      assign data_in  = operands;
      assign valid_in = inValid;
    end else begin : g_next
      assign data_in  = g_stage[k-1].data_out;
      assign valid_in = g_stage[k-1].valid_out;
    end

    pipelined_add_stage #(
      .laneCount (inLanes),
      .laneBits  (inBits),
      .clampBits (stageClamp)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .advance_i (advance),
      .valid_i   (valid_in),
      .data_i    (data_in),
      .valid_o   (valid_out),
      .data_o    (data_out)
    );
  end

  assign result   = g_stage[treeDepth].data_out;
  assign outValid = g_stage[treeDepth].valid_out;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Self-checking bench for pipelined_adder_tree: directed cases plus random
// traffic scored against an acceptance-order queue model.
module tb_pipelined_adder_tree;

  localparam int NB  = 8;
  localparam int NI  = 4;
  localparam int TD  = 2;
  localparam int RB  = NB + TD;
  localparam int NB2 = 16;
  localparam int NI2 = 8;
  localparam int RB2 = 19;

`ifdef ADDER_TREE_SATURATE_EN
  localparam int MAX4   = 255;
  localparam int STR3   = 255;
  localparam int BP_B   = 255;
  localparam int WIDEEXP = 65535;
`else
  localparam int MAX4   = 1020;
  localparam int STR3   = 256;
  localparam int BP_B   = 400;
  localparam int WIDEEXP = 524280;
`endif

  logic              clk;
  logic              rst;
  logic [NI*NB-1:0]  operands;
  logic              inValid;
  logic              inReady;
  logic [RB-1:0]     result;
  logic              outValid;
  logic              outReady;

  logic [NI2*NB2-1:0] operands_w;
  logic               inValid_w;
  logic               inReady_w;
  logic [RB2-1:0]     result_w;
  logic               outValid_w;
  logic               outReady_w;

  int checks;
  int errors;

  pipelined_adder_tree #(.numberOfBits(NB), .numberOfInputs(NI)) dut (
    .clock(clk), .reset(rst), .operands(operands), .inValid(inValid),
    .inReady(inReady), .result(result), .outValid(outValid), .outReady(outReady)
  );

  pipelined_adder_tree #(.numberOfBits(NB2), .numberOfInputs(NI2)) dut_w (
    .clock(clk), .reset(rst), .operands(operands_w), .inValid(inValid_w),
    .inReady(inReady_w), .result(result_w), .outValid(outValid_w), .outReady(outReady_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Plain arithmetic reference: sum of lanes, optionally clamped.
  function automatic logic [RB-1:0] model_sum(input logic [NI*NB-1:0] ops);
    int unsigned s;
    s = 0;
    for (int i = 0; i < NI; i++) s += ops[i*NB +: NB];
`ifdef ADDER_TREE_SATURATE_EN
    if (s > (1 << NB) - 1) s = (1 << NB) - 1;
`endif
    return RB'(s);
  endfunction

  // Scoreboard: accepted sums in order, each with the number of pipeline
  // advances it has seen; it is visible at the output after TD advances.
  typedef struct {
    logic [RB-1:0] sum;
    int            age;
  } entry_t;

  entry_t sb[$];
  bit     clean;
  bit     exp_v;
  bit     adv;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      clean = 1'b1;
    end else begin
      exp_v = (sb.size() > 0) && (sb[0].age >= TD);
      check("sb_outValid", outValid, exp_v);
      if (exp_v && outValid) check("sb_result", result, sb[0].sum);
      if (!outValid && clean) check("sb_result_after_reset", result, 0);
      check("sb_inReady", inReady, !exp_v || outReady);
      adv = !exp_v || outReady;
      if (exp_v && outReady) void'(sb.pop_front());
      if (adv) foreach (sb[i]) sb[i].age++;
      if (inValid && adv) sb.push_back('{sum: model_sum(operands), age: 1});
      if (inValid || operands != '0) clean = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inValid  = 1'b0;
    operands = '0;
  endtask

  task automatic drive(input logic [7:0] l3, input logic [7:0] l2,
                       input logic [7:0] l1, input logic [7:0] l0);
    operands = {l3, l2, l1, l0};
    inValid  = 1'b1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    inValid    = 1'b0;
    operands   = '0;
    outReady   = 1'b1;
    inValid_w  = 1'b0;
    operands_w = '0;
    outReady_w = 1'b1;

    check("model_pin_basic", model_sum({8'd4, 8'd3, 8'd2, 8'd1}), 10);
    check("model_pin_max", model_sum({NI*NB{1'b1}}), MAX4);

    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_outValid", outValid, 0);
    check("reset_result", result, 0);
    check("reset_inReady", inReady, 1);
    check("reset_wide_outValid", outValid_w, 0);

    // basic: 1,2,3,4 -> 10 two cycles later for one cycle
    tick(); drive(8'd4, 8'd3, 8'd2, 8'd1);
    tick(); idle();
    @(negedge clk); check("basic_lat1_outValid", outValid, 0);
    tick();
    @(negedge clk); check("basic_outValid", outValid, 1); check("basic_result", result, 10);
    tick();
    @(negedge clk); check("basic_pulse_end", outValid, 0);

    // max operands
    tick(); drive(8'd255, 8'd255, 8'd255, 8'd255);
    tick(); idle();
    tick();
    @(negedge clk); check("max_outValid", outValid, 1); check("max_result", result, MAX4);

    // streaming
    tick(); drive(8'd1, 8'd1, 8'd1, 8'd1);
    tick(); drive(8'd40, 8'd30, 8'd20, 8'd10);
    tick(); drive(8'd1, 8'd0, 8'd0, 8'd255);
    @(negedge clk); check("stream0_v", outValid, 1); check("stream0_result", result, 4);
    tick(); idle();
    @(negedge clk); check("stream1_v", outValid, 1); check("stream1_result", result, 100);
    tick();
    @(negedge clk); check("stream2_v", outValid, 1); check("stream2_result", result, STR3);
    tick();
    @(negedge clk); check("stream_end", outValid, 0);

    // backpressure
    tick(); drive(8'd4, 8'd3, 8'd2, 8'd1);
    tick(); drive(8'd100, 8'd100, 8'd100, 8'd100);
    tick(); drive(8'd0, 8'd0, 8'd0, 8'd7); outReady = 1'b0;
    @(negedge clk);
    check("bp_hold_v", outValid, 1); check("bp_hold_result", result, 10);
    check("bp_inReady", inReady, 0);
    repeat (3) tick();
    @(negedge clk);
    check("bp_hold_v_late", outValid, 1); check("bp_hold_result_late", result, 10);
    check("bp_inReady_late", inReady, 0);
    tick(); outReady = 1'b1;
    @(negedge clk);
    check("bp_drainA", result, 10); check("bp_inReady_release", inReady, 1);
    tick(); idle();
    @(negedge clk); check("bp_drainB_v", outValid, 1); check("bp_drainB", result, BP_B);
    tick();
    @(negedge clk); check("bp_drainC_v", outValid, 1); check("bp_drainC", result, 7);
    tick();
    @(negedge clk); check("bp_end", outValid, 0);

    // reset mid-flight
    tick(); drive(8'd5, 8'd5, 8'd5, 8'd5);
    tick(); idle(); rst = 1'b1;
    tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_flight_outValid", outValid, 0);
      check("rst_flight_result", result, 0);
      tick();
    end
    drive(8'd0, 8'd0, 8'd0, 8'd1);
    tick(); idle();
    @(negedge clk); check("rst_next_lat", outValid, 0);
    tick();
    @(negedge clk); check("rst_next_v", outValid, 1); check("rst_next_result", result, 1);

    // wide configuration
    tick(); operands_w = '1; inValid_w = 1'b1;
    tick(); operands_w = '0; inValid_w = 1'b0;
    @(negedge clk); check("wide_lat1", outValid_w, 0);
    tick();
    @(negedge clk); check("wide_lat2", outValid_w, 0);
    tick();
    @(negedge clk);
    check("wide_outValid", outValid_w, 1);
    check("wide_result", result_w, WIDEEXP);
    check("wide_resultBits", $bits(result_w), RB2);

    // random traffic with random backpressure and rare resets
    for (int n = 0; n < 3000; n++) begin
      tick();
      inValid  = 1'($urandom_range(0, 1));
      operands = ($urandom_range(0, 3) == 0) ? '1 : NI*NB'($urandom);
      outReady = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 399) == 0);
    end
    tick(); idle(); outReady = 1'b1; rst = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("drain_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
